// File: rtl/flappy_engine.sv
// flappy_engine: complete Flappy Bird game core.
// Bird physics, scrolling pipe field, collision, scoring, lives, pause and
// speed-up, driven by one two-process FSM. Row 0 is the bottom row.
module flappy_engine #(
    parameter int FIELD           = 16,
    parameter int BIRD_COL        = 13,
    parameter int GAP             = 4,
    parameter int PIPE_SPACING    = 4,
    parameter int GRAV_DIV        = 25000000,
    parameter int SCROLL_DIV_INIT = 12500000,
    parameter int SCROLL_DIV_MIN  = 3125000,
    parameter int SCROLL_STEP     = 1250000,
    parameter int SPEEDUP_EVERY   = 5,
    parameter int FLAP_UP         = 2,
    parameter int LIVES           = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flap,
    input  logic                           pause,
    input  logic [$clog2(FIELD)-1:0]       hole_rand,
    output logic [FIELD-1:0][FIELD-1:0]    red_pixels,
    output logic [FIELD-1:0][FIELD-1:0]    grn_pixels,
    output logic [9:0]                     score,
    output logic [2:0]                     lives,
    output logic [2:0]                     game_state,
    output logic                           game_over
);

    localparam int PW = $clog2(FIELD);
    localparam int GW = $clog2(GRAV_DIV + 1);
    localparam int SW = $clog2(SCROLL_DIV_INIT + 1);
    localparam int KW = $clog2(PIPE_SPACING + 1);
    localparam logic [PW-1:0]    MID       = PW'(FIELD / 2);
    localparam logic [FIELD-1:0] HOLE_ONES = FIELD'((64'(1) << GAP) - 64'(1));

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLAY   = 3'd1,
        S_PAUSED = 3'd2,
        S_HIT    = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [PW-1:0]              bird_q, bird_d;
    logic [FIELD-1:0][FIELD-1:0] cols_q, cols_d;
    logic [GW-1:0]              grav_q, grav_d;
    logic [SW-1:0]              scr_q, scr_d;
    logic [SW-1:0]              div_q, div_d;
    logic [KW-1:0]              spawn_q, spawn_d;
    logic [9:0]                 score_q, score_d;
    logic [2:0]                 lives_q, lives_d;

    logic                       grav_tick, scroll_tick;
    logic                       floor_hit, pipe_hit, collide;
    logic                       scored, speedup;
    logic [PW-1:0]              hole_h, bird_up;
    logic [FIELD-1:0]           pipe_mask;
    logic [SW-1:0]              div_dec;

    // Event decode from registered state: ticks, hits, pipe mask, saturations.
    always_comb begin
        grav_tick   = (grav_q == GW'(GRAV_DIV - 1));
        // >= so a divisor that shrank below the running count still wraps
        scroll_tick = (scr_q >= div_q - SW'(1));
        // flap cancels a coincident gravity tick, so it also prevents a floor hit
        floor_hit   = grav_tick && !flap && (bird_q == '0);
        pipe_hit    = cols_q[BIRD_COL][bird_q];
        collide     = pipe_hit || floor_hit;

        hole_h    = (int'(hole_rand) > FIELD - GAP) ? PW'(FIELD - GAP) : hole_rand;
        pipe_mask = ~(HOLE_ONES << hole_h);

        if (int'(bird_q) + FLAP_UP > FIELD - 1)
            bird_up = PW'(FIELD - 1);
        else
            bird_up = bird_q + PW'(FLAP_UP);

        scored  = scroll_tick && (cols_q[BIRD_COL] != '0) && (score_q != 10'd999);
        speedup = ((32'(score_q) + 32'd1) % SPEEDUP_EVERY) == 0;
        div_dec = (int'(div_q) <= SCROLL_DIV_MIN + SCROLL_STEP) ?
                  SW'(SCROLL_DIV_MIN) : div_q - SW'(SCROLL_STEP);
    end

    // Next-state logic: game FSM plus all counter, field and score updates.
    always_comb begin
        state_d = state_q;
        bird_d  = bird_q;
        cols_d  = cols_q;
        grav_d  = grav_q;
        scr_d   = scr_q;
        div_d   = div_q;
        spawn_d = spawn_q;
        score_d = score_q;
        lives_d = lives_q;

        case (state_q)
            S_IDLE: begin
                // the starting flap only launches play, it does not lift the bird
                if (flap) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (pause) begin
                    // pause beats everything in this cycle, including flap
                    state_d = S_PAUSED;
                end else if (collide) begin
                    // the field freezes as it was at the hit; no score this cycle
                    state_d = S_HIT;
                    lives_d = lives_q - 3'd1;
                end else begin
                    if (flap) begin
                        bird_d = bird_up;
                        grav_d = '0;
                    end else if (grav_tick) begin
                        bird_d = bird_q - PW'(1);
                        grav_d = '0;
                    end else begin
                        grav_d = grav_q + GW'(1);
                    end

                    if (scroll_tick) begin
                        scr_d              = '0;
                        cols_d[FIELD-1:1]  = cols_q[FIELD-2:0];
                        cols_d[0]          = (spawn_q == '0) ? pipe_mask : '0;
                        spawn_d            = (spawn_q == KW'(PIPE_SPACING - 1)) ?
                                             '0 : spawn_q + KW'(1);
                        if (scored) begin
                            score_d = score_q + 10'd1;
                            if (speedup) div_d = div_dec;
                        end
                    end else begin
                        scr_d = scr_q + SW'(1);
                    end
                end
            end
            S_PAUSED: begin
                if (!pause) state_d = S_PLAY;
            end
            S_HIT: begin
                if (lives_q == 3'd0) begin
                    state_d = S_OVER;
                end else begin
                    // new round keeps score and difficulty
                    state_d = S_IDLE;
                    cols_d  = '0;
                    bird_d  = MID;
                    grav_d  = '0;
                    scr_d   = '0;
                    spawn_d = '0;
                end
            end
            S_OVER: begin
                if (flap) begin
                    state_d = S_IDLE;
                    cols_d  = '0;
                    bird_d  = MID;
                    grav_d  = '0;
                    scr_d   = '0;
                    div_d   = SW'(SCROLL_DIV_INIT);
                    spawn_d = '0;
                    score_d = '0;
                    lives_d = 3'(LIVES);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bird_q  <= MID;
            cols_q  <= '0;
            grav_q  <= '0;
            scr_q   <= '0;
            div_q   <= SW'(SCROLL_DIV_INIT);
            spawn_q <= '0;
            score_q <= '0;
            lives_q <= 3'(LIVES);
        end else begin
            state_q <= state_d;
            bird_q  <= bird_d;
            cols_q  <= cols_d;
            grav_q  <= grav_d;
            scr_q   <= scr_d;
            div_q   <= div_d;
            spawn_q <= spawn_d;
            score_q <= score_d;
            lives_q <= lives_d;
        end
    end

    // Bird layer: a single pixel decoded from the bird register.
    always_comb begin
        red_pixels                   = '0;
        red_pixels[BIRD_COL][bird_q] = 1'b1;
    end

    assign grn_pixels = cols_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign game_state = state_q;
    assign game_over  = (state_q == S_OVER);

endmodule
